// File: rtl/run_detect_pkg.sv
// Shared types and constants for the run-of-ones detector controller.
package run_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HIT   = 2'd2
  } state_t;

  localparam int DEF_LEN_W = 4;
  localparam int DEF_CNT_W = 8;

  // A programmed run length of zero behaves as a run length of one.
  localparam int THRESH_ZERO_REMAP = 1;

endpackage

// File: rtl/run_detect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_sat
);

  logic [W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_sat = (r_cnt == {W{1'b1}});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/run_detect_ctrl.sv
// Run-of-ones detector controller: arm/disarm, threshold, event count, irq.
// Optional idle-input watchdog is built when RUN_DETECT_TIMEOUT_EN is defined.
module run_detect_ctrl
  import run_detect_pkg::*;
#(
  parameter int          LEN_W   = DEF_LEN_W,
  parameter int          CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cfg_wr,
  input  logic [LEN_W-1:0] i_cfg_run_len,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_in_valid,
  input  logic             i_in,
  input  logic             i_irq_ack,
  output logic             o_busy,
  output logic             o_det,
  output logic             o_irq,
  output logic [CNT_W-1:0] o_event_cnt,
  output logic             o_overflow,
  output logic             o_timeout
);

  localparam logic [LEN_W-1:0] RUN_MAX = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] THR_MIN = LEN_W'(THRESH_ZERO_REMAP);

  state_t           r_state;
  logic [LEN_W-1:0] r_threshold;
  logic [LEN_W-1:0] r_run_cnt;
  logic             r_busy;
  logic             r_det;
  logic             r_irq;
  logic             r_overflow;
  logic             r_timeout;

  logic             w_bit1;
  logic             w_bit0;
  logic             w_active;
  logic [LEN_W-1:0] w_run_inc;
  logic             w_arm;
  logic             w_event;
  logic             w_ev_sat;
  logic             w_wd_fire;

  assign w_bit1    = i_in_valid & i_in;
  assign w_bit0    = i_in_valid & ~i_in;
  assign w_active  = (r_state != ST_IDLE);
  assign w_run_inc = (r_run_cnt == RUN_MAX) ? RUN_MAX : r_run_cnt + 1'b1;
  assign w_arm     = (r_state == ST_IDLE) && i_start && !i_stop;
  // Only the ARMED->HIT transition is an event; a continued run in HIT is not.
  assign w_event   = (r_state == ST_ARMED) && w_bit1 && !i_stop &&
                     (w_run_inc == r_threshold);

  sat_counter #(.W(CNT_W)) u_event_cnt (
    .i_clk (i_clk),
    .i_rst (i_reset),
    .i_clr (w_arm),
    .i_inc (w_event),
    .o_cnt (o_event_cnt),
    .o_sat (w_ev_sat)
  );

`ifdef RUN_DETECT_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] w_wd_cnt;
  logic            w_wd_sat;

  sat_counter #(.W(WD_W)) u_watchdog (
    .i_clk (i_clk),
    .i_rst (i_reset),
    .i_clr (i_in_valid || !w_active),
    .i_inc (w_active && !i_in_valid),
    .o_cnt (w_wd_cnt),
    .o_sat (w_wd_sat)
  );

  // Fires on the TIMEOUT-th consecutive idle cycle so IDLE is visible right after it.
  assign w_wd_fire = w_active && !i_in_valid &&
                     ((w_wd_cnt == WD_W'(TIMEOUT - 1)) || w_wd_sat);
`else
  assign w_wd_fire = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_threshold <= THR_MIN;
      r_run_cnt   <= '0;
      r_busy      <= 1'b0;
      r_det       <= 1'b0;
      r_irq       <= 1'b0;
      r_overflow  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_irq <= (r_irq && !i_irq_ack) || w_event || w_wd_fire;

      if (w_event && w_ev_sat) begin
        r_overflow <= 1'b1;
      end else if (w_arm) begin
        r_overflow <= 1'b0;
      end

      if (w_wd_fire) begin
        r_timeout <= 1'b1;
      end else if (w_arm) begin
        r_timeout <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_cfg_wr) begin
            r_threshold <= (i_cfg_run_len == '0) ? THR_MIN : i_cfg_run_len;
          end
          if (w_arm) begin
            r_state   <= ST_ARMED;
            r_busy    <= 1'b1;
            r_run_cnt <= '0;
          end
        end
        ST_ARMED: begin
          if (i_stop || w_wd_fire) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_det   <= 1'b0;
          end else if (w_bit1) begin
            r_run_cnt <= w_run_inc;
            if (w_event) begin
              r_state <= ST_HIT;
              r_det   <= 1'b1;
            end
          end else if (w_bit0) begin
            r_run_cnt <= '0;
          end
        end
        ST_HIT: begin
          if (i_stop || w_wd_fire) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_det   <= 1'b0;
          end else if (w_bit1) begin
            r_run_cnt <= w_run_inc;
          end else if (w_bit0) begin
            r_state   <= ST_ARMED;
            r_det     <= 1'b0;
            r_run_cnt <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_det   <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_det      = r_det;
  assign o_irq      = r_irq;
  assign o_overflow = r_overflow;
  assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_run_detect_ctrl.sv
// Directed self-checking bench for run_detect_ctrl (watchdog checks follow RUN_DETECT_TIMEOUT_EN).
module tb_run_detect_ctrl;

  localparam int LEN_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_wr = 1'b0;
  logic [LEN_W-1:0] cfg_run_len = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             irq_ack = 1'b0;
  logic             busy, det, irq, overflow, timeout;
  logic [CNT_W-1:0] event_cnt;

  int checks = 0;
  int failures = 0;

  run_detect_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W), .TIMEOUT(10)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_cfg_wr      (cfg_wr),
    .i_cfg_run_len (cfg_run_len),
    .i_start       (start),
    .i_stop        (stop),
    .i_in_valid    (in_valid),
    .i_in          (in_bit),
    .i_irq_ack     (irq_ack),
    .o_busy        (busy),
    .o_det         (det),
    .o_irq         (irq),
    .o_event_cnt   (event_cnt),
    .o_overflow    (overflow),
    .o_timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; inputs are released one time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cfg_wr = 1'b0; start = 1'b0; stop = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic send(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    step();
  endtask

  task automatic show(input string what);
    $display("step %-24s busy=%0d det=%0d irq=%0d cnt=%0d ovf=%0d to=%0d",
             what, busy, det, irq, event_cnt, overflow, timeout);
  endtask

  initial begin
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_det", det, 0);
    chk("reset_irq", irq, 0);
    chk("reset_cnt", event_cnt, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_timeout", timeout, 0);
    show("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Threshold 4, run of 4 then continued run
    cfg_wr = 1'b1; cfg_run_len = 4'd4; step();
    start = 1'b1; step();
    chk("arm_busy", busy, 1);
    send(1'b1); send(1'b1); send(1'b1);
    chk("t4_det_after3", det, 0);
    send(1'b1);
    show("t4 fourth bit");
    chk("t4_det_after4", det, 1);
    chk("t4_irq_after4", irq, 1);
    chk("t4_cnt_after4", event_cnt, 1);
    send(1'b1); send(1'b1);
    chk("t4_det_cont", det, 1);
    chk("t4_cnt_cont", event_cnt, 1);
    irq_ack = 1'b1; step();
    chk("ack_clears_irq", irq, 0);
    chk("ack_det_holds", det, 1);

    // Threshold 3 with a broken run and an unqualified bit
    stop = 1'b1; step();
    chk("stop_busy", busy, 0);
    chk("stop_cnt_held", event_cnt, 1);
    cfg_wr = 1'b1; cfg_run_len = 4'd3; step();
    start = 1'b1; step();
    chk("start_clears_cnt", event_cnt, 0);
    cfg_wr = 1'b1; cfg_run_len = 4'd1; step();
    send(1'b1); send(1'b1);
    chk("t3_no_det_pair", det, 0);
    send(1'b0);
    in_bit = 1'b1; step();
    send(1'b1); send(1'b1);
    chk("t3_no_det_5", det, 0);
    send(1'b1);
    show("t3 sixth bit");
    chk("t3_det", det, 1);
    chk("t3_cnt", event_cnt, 1);

    // Threshold 0 remaps to 1
    stop = 1'b1; step();
    cfg_wr = 1'b1; cfg_run_len = 4'd0; step();
    start = 1'b1; step();
    send(1'b1);
    chk("t0_det", det, 1);
    send(1'b0);
    chk("t0_det_fall", det, 0);
    chk("t0_armed", busy, 1);
    chk("t0_cnt", event_cnt, 1);

    // Saturation: 255 events, then a 256th with irq_ack in the same cycle
    stop = 1'b1; step();
    start = 1'b1; step();
    for (int i = 0; i < 255; i++) begin
      send(1'b1);
      send(1'b0);
    end
    chk("sat_cnt_255", event_cnt, 255);
    chk("sat_no_ovf_yet", overflow, 0);
    irq_ack = 1'b1; step();
    chk("sat_ack_irq", irq, 0);
    irq_ack = 1'b1; send(1'b1);
    show("256th event");
    chk("sat_cnt_held", event_cnt, 255);
    chk("sat_ovf", overflow, 1);
    chk("sat_irq_set_wins", irq, 1);

    // stop+start in HIT, then again in IDLE
    stop = 1'b1; start = 1'b1; step();
    chk("ss_hit_busy", busy, 0);
    chk("ss_hit_det", det, 0);
    chk("ss_hit_cnt", event_cnt, 255);
    stop = 1'b1; start = 1'b1; step();
    chk("ss_idle_busy", busy, 0);
    chk("ss_idle_cnt", event_cnt, 255);
    chk("ss_idle_ovf", overflow, 1);

    // Async reset in the middle of a run
    cfg_wr = 1'b1; cfg_run_len = 4'd4; step();
    start = 1'b1; step();
    send(1'b1); send(1'b1);
    chk("pre_rst_irq", irq, 1);
    #2 rst = 1'b1;
    #1;
    show("mid-run reset");
    chk("rst_busy", busy, 0);
    chk("rst_det", det, 0);
    chk("rst_irq", irq, 0);
    chk("rst_cnt", event_cnt, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Idle-input watchdog (threshold back to 1 after reset)
    start = 1'b1; step();
    for (int i = 0; i < 9; i++) step();
    chk("wd_busy_9", busy, 1);
    step();
    show("10 idle cycles");
`ifdef RUN_DETECT_TIMEOUT_EN
    chk("wd_busy_10", busy, 0);
    chk("wd_timeout", timeout, 1);
    chk("wd_irq", irq, 1);
    start = 1'b1; step();
    chk("wd_start_clears", timeout, 0);
`else
    chk("wd_busy_10", busy, 1);
    chk("wd_timeout", timeout, 0);
    chk("wd_irq", irq, 0);
    send(1'b1);
    chk("wd_still_armed_det", det, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_detect_ctrl.md
Name: run_detect_ctrl

Overview:
Controller that sequences a serial run-of-ones detector: arms and disarms it, holds a programmable run-length threshold, counts detection events and raises an interrupt with an acknowledge handshake. It sits between a register/CPU-side control interface and the serial bit stream. Detection is Moore-style: the run-detected output depends on state only.

Parameters:
LEN_W, 4, width of cfg_run_len and the internal run counter
CNT_W, 8, width of event_cnt
TIMEOUT, 255, idle-input watchdog limit in cycles (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cfg_wr  input  1  load cfg_run_len into threshold register
cfg_run_len  input  LEN_W  required run length; 0 is treated as 1
start  input  1  arm detector (pulse)
stop  input  1  disarm detector (pulse)
in_valid  input  1  serial bit qualifier
in  input  1  serial data bit
irq_ack  input  1  clears irq
busy  output  1  state != IDLE
det  output  1  high while state == HIT
irq  output  1  sticky event interrupt
event_cnt  output  CNT_W  saturating event count
overflow  output  1  sticky: event arrived while event_cnt was at max
timeout  output  1  sticky watchdog flag (0 when feature is compiled out)

Behaviour:
- Reset (async, high): state=IDLE, threshold=1, run_cnt=0, busy=0, det=0, irq=0, event_cnt=0, overflow=0, timeout=0.
- All outputs are registered. Single clock domain.
- States: IDLE, ARMED, HIT.
- IDLE:
  - cfg_wr loads the threshold (0 loads as 1). cfg_wr in any other state is ignored.
  - start -> ARMED; clears run_cnt, event_cnt, overflow and timeout.
  - stop and start in the same cycle: stop wins and the block stays IDLE.
- ARMED:
  - in_valid&&in: run_cnt+1. If run_cnt+1 == threshold -> HIT, event_cnt+1, irq set.
  - in_valid&&!in: run_cnt=0.
  - !in_valid: hold; bits without in_valid are ignored everywhere.
- HIT:
  - in_valid&&in: stay in HIT. A continued run produces no new event.
  - in_valid&&!in: -> ARMED, run_cnt=0.
- stop in ARMED or HIT -> IDLE next edge. det falls the same edge; irq and event_cnt hold.
- Latency: the qualifying bit is sampled at edge N; det=1, irq=1 and the incremented event_cnt are visible after edge N. det falls one cycle after the terminating 0 bit.
- Threshold 1: a single 1 bit in ARMED enters HIT.
- run_cnt saturates at 2^LEN_W-1 and never wraps.
- event_cnt saturates at 2^CNT_W-1. A further event sets overflow and still sets irq.
- irq_ack clears irq. A new event in the same cycle as irq_ack leaves irq=1 (set wins).
- Reset asserted mid-run returns the block to reset values immediately; no event is counted.

Optional Feature:
Macro: RUN_DETECT_TIMEOUT_EN
- Defined: a watchdog counts consecutive cycles without in_valid while in ARMED or HIT. On reaching TIMEOUT the block goes to IDLE, sets timeout (sticky, cleared by start or reset) and sets irq. Any in_valid clears the watchdog count.
- Undefined: no watchdog logic; timeout is tied to 0; the TIMEOUT parameter is unused.

Decomposition:
- Package run_detect_pkg holds:
  - the state enum (IDLE=0, ARMED=1, HIT=2) as a 2-bit typedef;
  - default LEN_W and CNT_W constants;
  - a helper constant for the threshold-zero remap.
- One sub-module, sat_counter, parameterised by width with inc/clr inputs and a sat output. It is instantiated for event_cnt and for the watchdog.

Test Plan:
- Reset, cfg_run_len=4, start, bits 1,1,1,1 with in_valid -> det=1 and irq=1 after the 4th bit edge, event_cnt=1. Then bits 1,1 -> det stays 1, event_cnt stays 1.
- cfg_run_len=3, bits 1,1,0,1,1,1 -> no det after the first pair; det after the 6th bit; event_cnt=1.
- cfg_run_len=0, start, single 1 -> det after 1 bit. Then a 0 bit -> det=0 next cycle, state ARMED.
- CNT_W=8: 256 events of threshold 1 separated by 0 bits -> event_cnt=255, overflow=1, irq=1. Also irq_ack in the same cycle as an event -> irq stays 1.
- In HIT, assert stop and start together -> IDLE, busy=0, event_cnt retained. Assert reset mid-run of 2 ones (threshold 4) -> all outputs 0 immediately.
- With RUN_DETECT_TIMEOUT_EN and TIMEOUT=10: arm, hold in_valid=0 for 10 cycles -> state IDLE, timeout=1, irq=1. Without the macro -> block stays ARMED, timeout=0.
